// File: rtl/elevator_pkg.sv
// Shared state encodings, direction constants and sensor decode helpers
// for the SCAN elevator controller.
package elevator_pkg;

   localparam int MAX_FLOORS = 64;

   localparam logic [2:0] ST_IDLE        = 3'd0;
   localparam logic [2:0] ST_MOVING_UP   = 3'd1;
   localparam logic [2:0] ST_MOVING_DOWN = 3'd2;
   localparam logic [2:0] ST_DOOR_OPEN   = 3'd3;
   localparam logic [2:0] ST_DOOR_CLOSE  = 3'd4;
   localparam logic [2:0] ST_FAULT       = 3'd5;

   localparam logic DIR_UP   = 1'b1;
   localparam logic DIR_DOWN = 1'b0;

   function automatic logic [5:0] onehot_to_index(input logic [MAX_FLOORS-1:0] vec);
      logic [5:0] idx;
      idx = 6'd0;
      for (int i = 0; i < MAX_FLOORS; i++) begin
         idx = idx | (vec[i] ? 6'(i) : 6'd0);
      end
      return idx;
   endfunction

   function automatic logic multi_hot(input logic [MAX_FLOORS-1:0] vec);
      logic [6:0] cnt;
      cnt = 7'd0;
      for (int i = 0; i < MAX_FLOORS; i++) begin
         cnt = cnt + 7'(vec[i]);
      end
      return (cnt > 7'd1);
   endfunction

endpackage

// File: rtl/elevator_scan_controller_request_bank.sv
// Cab / hall call latches with service clearing and above/below/here lookup
// relative to the floor the controller is currently evaluating.
module elevator_request_bank
   import elevator_pkg::*;
#(
   parameter int NUM_FLOORS = 8,
   parameter int FLOOR_BITS = 3
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic [NUM_FLOORS-1:0] internal_set,
   input  logic [NUM_FLOORS-1:0] up_set,
   input  logic [NUM_FLOORS-1:0] down_set,
   input  logic [FLOOR_BITS-1:0] floor,
   input  logic                  dir_up,
   input  logic                  service,
   input  logic                  flush,
   output logic                  any_above,
   output logic                  any_below,
   output logic                  here_internal,
   output logic                  here_up,
   output logic                  here_down,
   output logic                  new_here,
   output logic [NUM_FLOORS-1:0] pending
);

   localparam logic [NUM_FLOORS-1:0] UP_MASK   = {1'b0, {(NUM_FLOORS-1){1'b1}}};
   localparam logic [NUM_FLOORS-1:0] DOWN_MASK = {{(NUM_FLOORS-1){1'b1}}, 1'b0};

   logic [NUM_FLOORS-1:0] int_r, up_r, down_r;
   logic [NUM_FLOORS-1:0] eff_int, eff_up, eff_down, eff_any, new_any;
   logic [NUM_FLOORS-1:0] clr_int, clr_up, clr_down;
   logic [NUM_FLOORS-1:0] int_next, up_next, down_next;

   // Calls arriving this cycle count as already latched so a stop can serve them.
   assign eff_int  = int_r | internal_set;
   assign eff_up   = up_r | (up_set & UP_MASK);
   assign eff_down = down_r | (down_set & DOWN_MASK);
   assign eff_any  = eff_int | eff_up | eff_down;
   assign new_any  = internal_set | (up_set & UP_MASK) | (down_set & DOWN_MASK);

   assign here_internal = eff_int[floor];
   assign here_up       = eff_up[floor];
   assign here_down     = eff_down[floor];
   assign new_here      = new_any[floor];

   // Look for outstanding calls strictly above and below the evaluated floor.
   always_comb begin
      any_above = 1'b0;
      any_below = 1'b0;
      for (int i = 0; i < NUM_FLOORS; i++) begin
         any_above = any_above | (eff_any[i] & (FLOOR_BITS'(i) > floor));
         any_below = any_below | (eff_any[i] & (FLOOR_BITS'(i) < floor));
      end
   end

   // Service clears the cab call and the hall calls this stop satisfies.
   always_comb begin
      clr_int  = '0;
      clr_up   = '0;
      clr_down = '0;
      if (service) begin
         clr_int[floor]  = 1'b1;
         clr_up[floor]   = dir_up | ~any_below;
         clr_down[floor] = ~dir_up | ~any_above;
      end else begin
         clr_int = '0;
      end
   end

   assign int_next  = flush ? '0 : (eff_int & ~clr_int);
   assign up_next   = flush ? '0 : (eff_up & ~clr_up);
   assign down_next = flush ? '0 : (eff_down & ~clr_down);

   // Latch storage and the registered per-floor pending summary.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         int_r   <= '0;
         up_r    <= '0;
         down_r  <= '0;
         pending <= '0;
      end else begin
         int_r   <= int_next;
         up_r    <= up_next;
         down_r  <= down_next;
         pending <= int_next | up_next | down_next;
      end
   end

endmodule

// File: rtl/elevator_scan_controller.sv
// SCAN-order elevator car controller: motion and door sequencing, floor
// tracking, and sticky fault on sensor conflict or travel timeout.
module elevator_scan_controller
   import elevator_pkg::*;
#(
   parameter int NUM_FLOORS        = 8,
   parameter int FLOOR_BITS        = 3,
   parameter int DOOR_OPEN_CYCLES  = 32,
   parameter int DOOR_CLOSE_CYCLES = 8,
   parameter int TRAVEL_TIMEOUT    = 256
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic [NUM_FLOORS-1:0] internal_requests,
   input  logic [NUM_FLOORS-1:0] external_up_requests,
   input  logic [NUM_FLOORS-1:0] external_down_requests,
   input  logic [NUM_FLOORS-1:0] floor_sensors,
   input  logic                  door_obstruct,
   output logic                  motor_up,
   output logic                  motor_down,
   output logic                  door_open,
   output logic                  door_close,
   output logic [FLOOR_BITS-1:0] current_floor,
   output logic                  direction_up,
   output logic [NUM_FLOORS-1:0] pending_requests,
   output logic                  fault
);

   localparam logic [15:0] OPEN_LOAD   = 16'(DOOR_OPEN_CYCLES - 1);
   localparam logic [15:0] CLOSE_LOAD  = 16'(DOOR_CLOSE_CYCLES - 1);
   localparam logic [15:0] TRAVEL_LAST = 16'(TRAVEL_TIMEOUT - 1);

   logic [2:0]            state_r, state_next;
   logic                  dir_next;
   logic [15:0]           timer_r, timer_next, travel_r, travel_next;
   logic [NUM_FLOORS-1:0] sensors_prev_r;
   logic [FLOOR_BITS-1:0] sensor_idx, eval_floor;
   logic                  sensor_multi, sensor_one, sensor_change, sensor_edge;
   logic                  any_above, any_below, here_int, here_up, here_down, new_here;
   logic                  here_any, going_up, ahead, behind, dir_match;

   assign sensor_idx    = FLOOR_BITS'(onehot_to_index(MAX_FLOORS'(floor_sensors)));
   assign sensor_multi  = multi_hot(MAX_FLOORS'(floor_sensors));
   assign sensor_one    = (floor_sensors != '0) & ~sensor_multi;
   assign sensor_change = (floor_sensors != sensors_prev_r);
   assign sensor_edge   = sensor_one & sensor_change;
   assign eval_floor    = sensor_one ? sensor_idx : current_floor;

   assign here_any  = here_int | here_up | here_down;
   assign going_up  = (state_r == ST_MOVING_UP);
   assign ahead     = going_up ? any_above : any_below;
   assign behind    = going_up ? any_below : any_above;
   assign dir_match = going_up ? here_up : here_down;

   elevator_request_bank #(
      .NUM_FLOORS (NUM_FLOORS),
      .FLOOR_BITS (FLOOR_BITS)
   ) u_bank (
      .clk           (clk),
      .reset_n       (reset_n),
      .internal_set  (internal_requests),
      .up_set        (external_up_requests),
      .down_set      (external_down_requests),
      .floor         (eval_floor),
      .dir_up        (dir_next),
      .service       (state_next == ST_DOOR_OPEN),
      .flush         (state_next == ST_FAULT),
      .any_above     (any_above),
      .any_below     (any_below),
      .here_internal (here_int),
      .here_up       (here_up),
      .here_down     (here_down),
      .new_here      (new_here),
      .pending       (pending_requests)
   );

   // Next-state, direction and timer decisions.
   always_comb begin
      state_next  = state_r;
      dir_next    = direction_up;
      timer_next  = timer_r;
      travel_next = 16'd0;
      if (sensor_multi) begin
         state_next = ST_FAULT;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (here_any) begin
                  state_next = ST_DOOR_OPEN;
                  timer_next = OPEN_LOAD;
                  // Align direction with a lone hall call so the stop clears it.
                  if (here_down & ~here_up & ~here_int) begin
                     dir_next = DIR_DOWN;
                  end else if (here_up & ~here_down & ~here_int) begin
                     dir_next = DIR_UP;
                  end else begin
                     dir_next = direction_up;
                  end
               end else if (any_above & ((direction_up == DIR_UP) | ~any_below)) begin
                  state_next = ST_MOVING_UP;
                  dir_next   = DIR_UP;
               end else if (any_below) begin
                  state_next = ST_MOVING_DOWN;
                  dir_next   = DIR_DOWN;
               end else begin
                  state_next = ST_IDLE;
               end
            end
            ST_MOVING_UP, ST_MOVING_DOWN: begin
               if (sensor_edge) begin
                  if (here_int | dir_match | (~ahead & here_any)) begin
                     state_next = ST_DOOR_OPEN;
                     timer_next = OPEN_LOAD;
                  end else if (ahead) begin
                     state_next = state_r;
                  end else if (behind) begin
                     state_next = going_up ? ST_MOVING_DOWN : ST_MOVING_UP;
                     dir_next   = going_up ? DIR_DOWN : DIR_UP;
                  end else begin
                     state_next = ST_IDLE;
                  end
               end else if (sensor_change) begin
                  travel_next = 16'd0;
               end else if (travel_r == TRAVEL_LAST) begin
                  state_next = ST_FAULT;
               end else begin
                  travel_next = travel_r + 16'd1;
               end
            end
            ST_DOOR_OPEN: begin
               if (door_obstruct | new_here) begin
                  timer_next = OPEN_LOAD;
               end else if (timer_r == 16'd0) begin
                  state_next = ST_DOOR_CLOSE;
                  timer_next = CLOSE_LOAD;
               end else begin
                  timer_next = timer_r - 16'd1;
               end
            end
            ST_DOOR_CLOSE: begin
               if (door_obstruct | new_here) begin
                  state_next = ST_DOOR_OPEN;
                  timer_next = OPEN_LOAD;
               end else if (timer_r == 16'd0) begin
                  state_next = ST_IDLE;
                  timer_next = 16'd0;
               end else begin
                  timer_next = timer_r - 16'd1;
               end
            end
            ST_FAULT: begin
               state_next = ST_FAULT;
            end
            default: begin
               state_next = ST_FAULT;
            end
         endcase
      end
   end

   // State, tracking registers and drivers decoded from the next state.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_r        <= ST_IDLE;
         timer_r        <= 16'd0;
         travel_r       <= 16'd0;
         sensors_prev_r <= '0;
         current_floor  <= '0;
         direction_up   <= DIR_UP;
         motor_up       <= 1'b0;
         motor_down     <= 1'b0;
         door_open      <= 1'b0;
         door_close     <= 1'b0;
         fault          <= 1'b0;
      end else begin
         state_r        <= state_next;
         timer_r        <= timer_next;
         travel_r       <= travel_next;
         sensors_prev_r <= floor_sensors;
         current_floor  <= eval_floor;
         direction_up   <= dir_next;
         motor_up       <= (state_next == ST_MOVING_UP);
         motor_down     <= (state_next == ST_MOVING_DOWN);
         door_open      <= (state_next == ST_DOOR_OPEN);
         door_close     <= (state_next == ST_DOOR_CLOSE);
         fault          <= (state_next == ST_FAULT);
      end
   end

endmodule
